// File: rtl/ch_gain_cal_mul_rnd_sat.sv
// Pipelined multi-lane gain multiplier: per-lane product with a common gain,
// round-half-up and right shift, saturation to OUT_W, valid pipeline and saturation counter.
module ch_gain_cal_mul_rnd_sat #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned A_W      = 16,
  parameter int unsigned B_W      = 17,
  parameter bit          A_SIGNED = 1'b1,
  parameter bit          B_SIGNED = 1'b0,
  parameter int unsigned SHIFT    = 15,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned LATENCY  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [LANES*A_W-1:0]   din_a,
  input  logic [B_W-1:0]         din_b,
  input  logic                   clr_stats,
  output logic                   out_valid,
  output logic [LANES*OUT_W-1:0] dout,
  output logic [LANES-1:0]       sat_flag,
  output logic [15:0]            sat_count
);

  localparam bit          OUT_SIGNED = A_SIGNED | B_SIGNED;
  localparam int unsigned P_W        = A_W + B_W;
  // Product of two operands each extended by one bit; always interpreted as signed.
  localparam int unsigned M_W        = P_W + 2;
  localparam int unsigned X_W        = (M_W > OUT_W + 2) ? M_W : OUT_W + 2;
  // Stage 3 plus the pure delay stages behind it.
  localparam int unsigned D_N        = LATENCY - 2;

  localparam logic signed [X_W-1:0] RND =
    X_W'(SHIFT != 0) << ((SHIFT == 0) ? 0 : SHIFT - 1);
  localparam logic signed [X_W-1:0] SAT_HI =
    (X_W'(1) << (OUT_W - (OUT_SIGNED ? 1 : 0))) - X_W'(1);
  localparam logic signed [X_W-1:0] SAT_LO =
    OUT_SIGNED ? (X_W'(0) - (X_W'(1) << (OUT_W - 1))) : X_W'(0);

  // Elaboration-time parameter legality.
  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("ch_gain_cal_mul_rnd_sat: LANES must be 1..4");
  end
  if (SHIFT > P_W - 1) begin : g_bad_shift
    $error("ch_gain_cal_mul_rnd_sat: SHIFT must be 0..A_W+B_W-1");
  end
  if (LATENCY < 3 || LATENCY > 8) begin : g_bad_latency
    $error("ch_gain_cal_mul_rnd_sat: LATENCY must be 3..8");
  end

  logic [LANES*A_W-1:0]   s1_a;
  logic [B_W-1:0]         s1_b;
  logic                   s1_v;
  logic signed [M_W-1:0]  s2_p [LANES];
  logic                   s2_v;
  logic [LANES*OUT_W-1:0] pd   [D_N];
  logic [LANES-1:0]       pf   [D_N];
  logic [D_N-1:0]         pv;
  logic [15:0]            cnt;

  logic signed [B_W:0]    b_x;
  logic signed [M_W-1:0]  prod_c [LANES];
  logic [LANES*OUT_W-1:0] res_c;
  logic [LANES-1:0]       sat_c;

  assign b_x = {B_SIGNED & s1_b[B_W-1], s1_b};

  // Per-lane multiply (stage 2 input) and round/shift/clamp (stage 3 input).
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [A_W:0]   a_x;
    logic signed [X_W-1:0] p_x;
    logic signed [X_W-1:0] r_x;
    logic                  hi_c;
    logic                  lo_c;

    assign a_x       = {A_SIGNED & s1_a[l*A_W + A_W - 1], s1_a[l*A_W +: A_W]};
    assign prod_c[l] = M_W'(a_x) * M_W'(b_x);
    assign p_x       = X_W'(s2_p[l]);
    assign r_x       = (p_x + RND) >>> SHIFT;
    assign hi_c      = r_x > SAT_HI;
    assign lo_c      = r_x < SAT_LO;
    assign sat_c[l]  = hi_c | lo_c;
    assign res_c[l*OUT_W +: OUT_W] = hi_c ? OUT_W'(SAT_HI) :
                                     lo_c ? OUT_W'(SAT_LO) : OUT_W'(r_x);
  end

  // Stages 1 and 2; data registers only load behind a valid so outputs hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_a <= '0;
      s1_b <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      for (int l = 0; l < LANES; l++) s2_p[l] <= '0;
    end else if (ce) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a <= din_a;
        s1_b <= din_b;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        for (int l = 0; l < LANES; l++) s2_p[l] <= prod_c[l];
      end
    end
  end

  // Stage 3 result register followed by the output delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int k = 0; k < D_N; k++) begin
        pd[k] <= '0;
        pf[k] <= '0;
      end
    end else if (ce) begin
      pv[0] <= s2_v;
      if (s2_v) begin
        pd[0] <= res_c;
        pf[0] <= sat_c;
      end
      for (int k = 1; k < D_N; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          pd[k] <= pd[k-1];
          pf[k] <= pf[k-1];
        end
      end
    end
  end

  // Saturation event counter; clear wins over increment, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (ce) begin
      if (clr_stats) begin
        cnt <= '0;
      end else if (out_valid && (|sat_flag) && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign out_valid = pv[D_N-1];
  assign dout      = pd[D_N-1];
  assign sat_flag  = pf[D_N-1];
  assign sat_count = cnt;

endmodule

// File: tb/tb_ch_gain_cal_mul_rnd_sat.sv
// Scoreboard bench: default-parameter instance plus an unsigned SHIFT=0, LATENCY=3, single-lane instance.
module tb_ch_gain_cal_mul_rnd_sat;

  localparam int LAT  = 4;
  localparam int SH   = 15;
  localparam int OW   = 16;
  localparam int LAT2 = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce, in_valid, clr_stats;
  logic [31:0] din_a;
  logic [16:0] din_b;
  logic        out_valid;
  logic [31:0] dout;
  logic [1:0]  sat_flag;
  logic [15:0] sat_count;

  logic        rst2, ce2, iv2, clr2;
  logic [15:0] a2;
  logic [16:0] b2;
  logic        ov2;
  logic [32:0] d2;
  logic [0:0]  f2;
  logic [15:0] c2;

  ch_gain_cal_mul_rnd_sat dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din_a(din_a), .din_b(din_b),
    .clr_stats(clr_stats), .out_valid(out_valid), .dout(dout), .sat_flag(sat_flag),
    .sat_count(sat_count)
  );

  ch_gain_cal_mul_rnd_sat #(
    .LANES(1), .A_W(16), .B_W(17), .A_SIGNED(1'b0), .B_SIGNED(1'b0),
    .SHIFT(0), .OUT_W(33), .LATENCY(LAT2)
  ) dut2 (
    .clk(clk), .reset(rst2), .ce(ce2), .in_valid(iv2), .din_a(a2), .din_b(b2),
    .clr_stats(clr2), .out_valid(ov2), .dout(d2), .sat_flag(f2), .sat_count(c2)
  );

  typedef struct { logic [31:0] d; logic [1:0] f; int due; } exp_t;
  typedef struct { logic [32:0] d; logic f; int due; } exp2_t;

  exp_t  sb[$];
  exp2_t sb2[$];
  int    vectors = 0, miscompares = 0;
  int    en_edges = 0, last_en = 0, en2 = 0, last2 = 0;
  logic        exp_ov = 1'b0;
  logic [1:0]  exp_f = 2'b00;
  int    mcount = 0;
  bit    done2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference: floor((p + 2^(sh-1)) / 2^sh), then clamp to the output range.
  function automatic longint rnd_sat(input longint p, input int sh, input int ow,
                                     input bit sg, output bit f);
    longint n, d, q, hi, lo;
    if (sh > 0) begin
      n = p + (longint'(1) << (sh - 1));
      d = longint'(1) << sh;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
    end else begin
      q = p;
    end
    hi = sg ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
    lo = sg ? -(longint'(1) << (ow - 1)) : 0;
    f = 1'b0;
    if (q > hi) begin q = hi; f = 1'b1; end
    else if (q < lo) begin q = lo; f = 1'b1; end
    return q;
  endfunction

  function automatic logic [31:0] pk(input int l0, input int l1);
    return {16'(l1), 16'(l0)};
  endfunction

  // Main instance: expected results queued at the capturing edge, counter model advanced.
  always @(posedge clk) begin
    if (reset === 1'b0 && ce === 1'b1) begin
      exp_t e;
      en_edges++;
      if (clr_stats) mcount = 0;
      else if (exp_ov && (|exp_f) && mcount < 65535) mcount++;
      if (in_valid) begin
        for (int l = 0; l < 2; l++) begin
          logic [15:0] al;
          longint r;
          bit fl;
          al = din_a[l*16 +: 16];
          r = rnd_sat(longint'($signed(al)) * longint'(din_b), SH, OW, 1'b1, fl);
          e.d[l*16 +: 16] = 16'(r);
          e.f[l] = fl;
        end
        e.due = en_edges + LAT - 1;
        sb.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && en_edges != last_en) begin
      last_en = en_edges;
      if (sb.size() > 0 && sb[0].due == en_edges) begin
        exp_t e;
        e = sb.pop_front();
        exp_ov = 1'b1;
        exp_f = e.f;
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("dout", 64'(dout), 64'(e.d));
        chk("sat_flag", 64'(sat_flag), 64'(e.f));
      end else begin
        exp_ov = 1'b0;
        chk("out_valid_idle", 64'(out_valid), 64'd0);
      end
      chk("sat_count", 64'(sat_count), 64'(mcount));
    end
  end

  // Second instance: full unsigned product, never saturating.
  always @(posedge clk) begin
    if (rst2 === 1'b0) begin
      exp2_t e;
      bit fl;
      en2++;
      if (iv2) begin
        e.d = 33'(rnd_sat(longint'(a2) * longint'(b2), 0, 33, 1'b0, fl));
        e.f = fl;
        e.due = en2 + LAT2 - 1;
        sb2.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst2 === 1'b0 && en2 != last2) begin
      last2 = en2;
      if (sb2.size() > 0 && sb2[0].due == en2) begin
        exp2_t e;
        e = sb2.pop_front();
        chk("u2_out_valid", 64'(ov2), 64'd1);
        chk("u2_dout", 64'(d2), 64'(e.d));
        chk("u2_sat_flag", 64'(f2), 64'(e.f));
      end else begin
        chk("u2_out_valid_idle", 64'(ov2), 64'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [16:0] b,
                       input logic c_e, input logic clr);
    in_valid = v; din_a = a; din_b = b; ce = c_e; clr_stats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset_check();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    sb.delete();
    mcount = 0;
    exp_ov = 1'b0;
    exp_f = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    rst2 = 1'b0; ce2 = 1'b1; clr2 = 1'b0; iv2 = 1'b0; a2 = '0; b2 = '0;
    #2 rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      iv2 = 1'($urandom);
      a2  = 16'($urandom);
      b2  = 17'($urandom);
      if ($urandom_range(0, 15) == 0) begin a2 = 16'hFFFF; b2 = 17'h1FFFF; end
      @(posedge clk);
      #1;
    end
    iv2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("u2_sat_count", 64'(c2), 64'd0);
    done2 = 1'b1;
  end

  initial begin
    reset = 1'b0; ce = 1'b0; in_valid = 1'b0; clr_stats = 1'b0; din_a = '0; din_b = '0;
    #1;
    do_reset_check();

    // Unity gain, single pulse.
    drive(1'b1, pk(1000, -1000), 17'd32768, 1'b1, 1'b0);
    idle(6);
    // Rounding ties and near-ties.
    drive(1'b1, pk(1, -1), 17'd16384, 1'b1, 1'b0);
    drive(1'b1, pk(3, -3), 17'd16384, 1'b1, 1'b0);
    idle(6);
    // Saturation both directions, then a clean sample.
    drive(1'b1, pk(32767, -32768), 17'h1FFFF, 1'b1, 1'b0);
    drive(1'b1, pk(10, 0), 17'd32768, 1'b1, 1'b0);
    idle(6);
    chk("sat_count_after_sat", 64'(sat_count), 64'd1);
    // Back-to-back samples with a three-cycle stall after the third.
    for (int i = 1; i <= 3; i++) drive(1'b1, pk(i, -i), 17'd32768, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, pk(99, 99), 17'd99, 1'b0, 1'b1);
    for (int i = 4; i <= 6; i++) drive(1'b1, pk(i, -i), 17'd32768, 1'b1, 1'b0);
    idle(8);
    // Reset with samples in flight.
    drive(1'b1, pk(32767, 5), 17'h1FFFF, 1'b1, 1'b0);
    drive(1'b1, pk(7, 7), 17'd32768, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    do_reset_check();
    idle(10);
    // Randomized traffic with stalls and occasional clears.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom), $urandom, 17'($urandom), 1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 49) == 0));
    end
    idle(8);
    // Counter saturation at 0xFFFF, then clear coinciding with a saturating output.
    for (int i = 0; i < 65540; i++) drive(1'b1, pk(32767, -32768), 17'h1FFFF, 1'b1, 1'b0);
    chk("sat_count_limit", 64'(sat_count), 64'hFFFF);
    drive(1'b1, pk(32767, -32768), 17'h1FFFF, 1'b1, 1'b1);
    chk("clr_priority", 64'(sat_count), 64'd0);
    drive(1'b1, pk(32767, -32768), 17'h1FFFF, 1'b1, 1'b0);
    idle(8);

    for (int i = 0; i < 10000 && !done2; i++) @(posedge clk);
    chk("u2_done", 64'(done2), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("sb2_empty", 64'(sb2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
